// File: rtl/iir_batch_engine_pkg.sv
// Shared definitions for the IIR batch engine.
// Holds the FSM state encoding, the default memory map and the width
// constants used for lane packing and accumulator sizing.
package iir_batch_engine_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLoadCoef = 3'd1,
        StRun      = 3'd2,
        StDrain    = 3'd3,
        StDone     = 3'd4
    } state_t;

    localparam int unsigned COEF_BASE_DEF = 0;
    localparam int unsigned IN_BASE_DEF   = 2000;
    localparam int unsigned OUT_BASE_DEF  = 3000;

    // Coefficient words fetched per batch (a, b, c, d).
    localparam int unsigned NUM_COEF  = 4;
    // Extra accumulator bits above a full DWxDW product: four terms need two.
    localparam int unsigned ACC_GUARD = 2;
    // Width of the batch cycle counter.
    localparam int unsigned CNT_W     = 32;

endpackage

// File: rtl/iir_unfold_core.sv
// Unfolded second-order IIR datapath.
// Evaluates LANES consecutive outputs per enabled cycle, chaining the x/y
// history from lane to lane and from word to word.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : consume x_word and update y_word/history this cycle
//   clr         : clear the x/y history (has priority over en)
//   a, b, c, d  : signed coefficients, Q(DW-2) fixed point
//   x_word      : LANES packed input samples, lane 0 oldest
//   y_word      : LANES packed outputs, registered (latency 1)
module iir_unfold_core
    import iir_batch_engine_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned LANES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic signed [DW-1:0]  a,
    input  logic signed [DW-1:0]  b,
    input  logic signed [DW-1:0]  c,
    input  logic signed [DW-1:0]  d,
    input  logic [DW*LANES-1:0]   x_word,
    output logic [DW*LANES-1:0]   y_word
);

    localparam int unsigned ACC_W = 2 * DW + ACC_GUARD;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [DW-1:0]    r_x1, r_y1, r_y2;
    logic signed [DW-1:0]    w_x1, w_y1, w_y2, w_xl, w_yl;
    logic signed [ACC_W-1:0] w_acc, w_sh;
    logic [DW*LANES-1:0]     w_y_word;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [DW-1:0] v);
        return {{(ACC_W-DW){v[DW-1]}}, v};
    endfunction

    // Lane i sees the history left behind by lane i-1 in the same cycle.
    always_comb begin
        w_x1     = r_x1;
        w_y1     = r_y1;
        w_y2     = r_y2;
        w_xl     = '0;
        w_yl     = '0;
        w_acc    = '0;
        w_sh     = '0;
        w_y_word = '0;
        for (int i = 0; i < LANES; i++) begin
            w_xl  = x_word[DW*i +: DW];
            w_acc = sext(c) * sext(w_xl) + sext(d) * sext(w_x1)
                  + sext(a) * sext(w_y1) + sext(b) * sext(w_y2);
            w_sh  = w_acc >>> (DW - 2);
            if (w_sh > SAT_MAX) begin
                w_yl = SAT_MAX[DW-1:0];
            end else if (w_sh < SAT_MIN) begin
                w_yl = SAT_MIN[DW-1:0];
            end else begin
                w_yl = w_sh[DW-1:0];
            end
            w_y_word[DW*i +: DW] = w_yl;
            w_x1 = w_xl;
            w_y2 = w_y1;
            w_y1 = w_yl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x1   <= '0;
            r_y1   <= '0;
            r_y2   <= '0;
            y_word <= '0;
        end else if (clr) begin
            r_x1 <= '0;
            r_y1 <= '0;
            r_y2 <= '0;
        end else if (en) begin
            r_x1   <= w_x1;
            r_y1   <= w_y1;
            r_y2   <= w_y2;
            y_word <= w_y_word;
        end
    end

endmodule

// File: rtl/iir_batch_engine.sv
// Batch IIR engine: fetches four coefficients, streams LEN input words
// through iir_unfold_core and writes LEN output words back to memory.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : batch request pulse, synchronous cancel
//   busy, done        : non-idle flag, one-cycle completion pulse
//   cycles            : RUN+DRAIN clock count of the last completed batch
//   rd_en/addr/data   : memory read port, data valid RD_LAT cycles after rd_en
//   wr_en/addr/data   : memory write port
module iir_batch_engine
    import iir_batch_engine_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned LANES     = 2,
    parameter int unsigned LEN       = 150,
    parameter int unsigned AW        = 16,
    parameter int unsigned COEF_BASE = COEF_BASE_DEF,
    parameter int unsigned IN_BASE   = IN_BASE_DEF,
    parameter int unsigned OUT_BASE  = OUT_BASE_DEF,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       cycles,
    output logic                   rd_en,
    output logic [AW-1:0]          rd_addr,
    input  logic [DW*LANES-1:0]    rd_data,
    output logic                   wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic [DW*LANES-1:0]    wr_data
);

    localparam logic [AW-1:0] A_COEF_FIRST = AW'(COEF_BASE);
    localparam logic [AW-1:0] A_COEF_LAST  = AW'(COEF_BASE + NUM_COEF - 1);
    localparam logic [AW-1:0] A_IN_FIRST   = AW'(IN_BASE);
    localparam logic [AW-1:0] A_IN_LAST    = AW'(IN_BASE + LEN - 1);
    localparam logic [AW-1:0] A_OUT_FIRST  = AW'(OUT_BASE);
    localparam logic [AW-1:0] A_OUT_LAST   = AW'(OUT_BASE + LEN - 1);

    state_t               r_state;
    logic                 r_busy, r_done, r_rd_en, r_wr_en;
    logic [CNT_W-1:0]     r_cycles, r_cnt;
    logic [AW-1:0]        r_rd_addr, r_wr_addr, r_wcnt;
    logic [RD_LAT-1:0]    r_vld;
    logic [1:0]           r_cap;
    logic signed [DW-1:0] r_a, r_b, r_c, r_d;

    logic                 w_core_en, w_core_clr;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [DW-1:0]        w_rd_lo;

    assign w_rd_lo    = rd_data[DW-1:0];
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    // Returning read data is a sample only while streaming; in LOAD_COEF it is a coefficient.
    assign w_core_en  = r_vld[RD_LAT-1] && (r_state == StRun || r_state == StDrain);
    assign w_core_clr = (r_state == StIdle) && start && !abort;

    assign busy    = r_busy;
    assign done    = r_done;
    assign cycles  = r_cycles;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;

    iir_unfold_core #(
        .DW    (DW),
        .LANES (LANES)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (w_core_en),
        .clr    (w_core_clr),
        .a      (r_a),
        .b      (r_b),
        .c      (r_c),
        .d      (r_d),
        .x_word (rd_data),
        .y_word (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cycles  <= '0;
            r_cnt     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wcnt    <= '0;
            r_vld     <= '0;
            r_cap     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_d       <= '0;
        end else begin
            r_done  <= 1'b0;
            // Core output register and write strobe advance together.
            r_wr_en <= w_core_en;
            if (w_core_en) begin
                r_wr_addr <= A_OUT_FIRST + r_wcnt;
                r_wcnt    <= r_wcnt + 1'b1;
            end
            for (int k = RD_LAT - 1; k > 0; k--) begin
                r_vld[k] <= r_vld[k-1];
            end
            r_vld[0] <= r_rd_en;

            if (abort && r_state != StIdle) begin
                // Drop everything in flight; cycles keeps the last completed batch.
                r_state <= StIdle;
                r_busy  <= 1'b0;
                r_rd_en <= 1'b0;
                r_wr_en <= 1'b0;
                r_vld   <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (start && !abort) begin
                            r_state   <= StLoadCoef;
                            r_busy    <= 1'b1;
                            r_cnt     <= '0;
                            r_wcnt    <= '0;
                            r_cap     <= '0;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= A_COEF_FIRST;
                        end
                    end
                    StLoadCoef: begin
                        if (r_rd_en) begin
                            if (r_rd_addr == A_COEF_LAST) begin
                                r_rd_en <= 1'b0;
                            end else begin
                                r_rd_addr <= r_rd_addr + 1'b1;
                            end
                        end
                        if (r_vld[RD_LAT-1]) begin
                            r_cap <= r_cap + 1'b1;
                            unique case (r_cap)
                                2'd0: r_a <= w_rd_lo;
                                2'd1: r_b <= w_rd_lo;
                                2'd2: r_c <= w_rd_lo;
                                2'd3: begin
                                    r_d       <= w_rd_lo;
                                    r_state   <= StRun;
                                    r_rd_en   <= 1'b1;
                                    r_rd_addr <= A_IN_FIRST;
                                end
                            endcase
                        end
                    end
                    StRun: begin
                        r_cnt <= w_cnt_inc;
                        if (r_rd_addr == A_IN_LAST) begin
                            r_rd_en <= 1'b0;
                            r_state <= StDrain;
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
                    end
                    StDrain: begin
                        r_cnt <= w_cnt_inc;
                        if (r_wr_en && r_wr_addr == A_OUT_LAST) begin
                            r_state  <= StDone;
                            r_done   <= 1'b1;
                            r_cycles <= w_cnt_inc;
                        end
                    end
                    StDone: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
